// File: rtl/cnt1_pkg.sv
// rtl/cnt1_pkg.sv - shared derivations and pipe sideband type for the popcount stream
package cnt1_pkg;

    // Valid bits carried by the final beat of a full vector.
    function automatic int last_bits(input int vector_width, input int bus_width, input int sub_vector_no);
        return vector_width - (sub_vector_no - 1) * bus_width;
    endfunction

    // Accepted beat to dn_Valid: mask stage + tree stages + accumulate stage.
    function automatic int lat(input int adder_stages);
        return adder_stages + 2;
    endfunction

    // Width of a single-beat popcount.
    function automatic int beat_cnt_width(input int bus_width);
        return $clog2(bus_width + 1);
    endfunction

    // Per-beat flags that ride alongside the data through the pipe.
    typedef struct packed {
        logic valid;
        logic first;
        logic is_end;
        logic err;
        logic last;
        logic mode;
    } sb_t;

endpackage

// File: rtl/cnt1_stream_if.sv
// rtl/cnt1_stream_if.sv - upstream beat, config and downstream count signals of cnt1_stream
//   slave  : view of the counting engine (consumes up_*, produces dn_*)
//   master : view of the surrounding source/sink
interface cnt1_stream_if #(
    parameter int BUS_WIDTH = 128,
    parameter int CNT_WIDTH = 10
) ();
    logic [BUS_WIDTH-1:0] up_Vector;
    logic                 up_Valid;
    logic                 up_Last;
    logic                 cfg_CountZeros;
    logic                 up_Ready;
    logic [BUS_WIDTH-1:0] dn_SubVector;
    logic                 dn_Valid;
    logic                 dn_Last;
    logic [CNT_WIDTH-1:0] dn_Cnt;
    logic                 dn_CntNew;
    logic                 dn_FrameErr;
    logic                 dn_Ready;

    modport slave (
        input  up_Vector, up_Valid, up_Last, cfg_CountZeros, dn_Ready,
        output up_Ready, dn_SubVector, dn_Valid, dn_Last, dn_Cnt, dn_CntNew, dn_FrameErr
    );

    modport master (
        output up_Vector, up_Valid, up_Last, cfg_CountZeros, dn_Ready,
        input  up_Ready, dn_SubVector, dn_Valid, dn_Last, dn_Cnt, dn_CntNew, dn_FrameErr
    );
endinterface

// File: rtl/popcnt_tree.sv
// rtl/popcnt_tree.sv - balanced pipelined popcount tree, STAGES register levels
//   clk      : clock
//   i_Vector : word to count, sampled when i_En
//   i_En     : advance all tree levels
//   o_Sum    : number of ones in i_Vector, STAGES enabled cycles later
module popcnt_tree #(
    parameter  int WIDTH  = 128,
    parameter  int STAGES = 3,
    localparam int SW     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] i_Vector,
    input  logic             i_En,
    output logic [SW-1:0]    o_Sum
);
    // Level 0 counts NG equal groups directly; each later level adds pairs,
    // halving the number of partial sums until one remains.
    localparam int NG = 1 << (STAGES - 1);
    localparam int GW = (WIDTH + NG - 1) / NG;
    localparam int NE = 2 * NG - 1;

    logic [NG*GW-1:0] vec_pad;
    logic [SW-1:0]    r_sum [NE];

    assign vec_pad = (NG*GW)'(i_Vector);

    // Partial sums of all levels share one flat array; level l starts here.
    function automatic int base(input int l);
        return 2 * NG - 2 * (NG >> l);
    endfunction

    function automatic logic [SW-1:0] grp_cnt(input logic [GW-1:0] v);
        logic [SW-1:0] c;
        c = '0;
        for (int i = 0; i < GW; i++) begin
            c = c + SW'(v[i]);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (i_En) begin
            for (int g = 0; g < NG; g++) begin
                r_sum[g] <= grp_cnt(vec_pad[g*GW +: GW]);
            end
            for (int l = 1; l < STAGES; l++) begin
                for (int g = 0; g < (NG >> l); g++) begin
                    r_sum[base(l) + g] <= r_sum[base(l-1) + 2*g] + r_sum[base(l-1) + 2*g + 1];
                end
            end
        end
    end

    assign o_Sum = r_sum[NE-1];
endmodule

// File: rtl/cnt1_stream.sv
// rtl/cnt1_stream.sv - streaming per-vector popcount with pad masking, zeros mode and frame check
//   clk, rstn : clock, synchronous active-low reset
//   bus.up_*  : input beats (up_Vector/up_Valid/up_Last, up_Ready back)
//   bus.cfg_CountZeros : count zeros for the vector starting on this beat
//   bus.dn_*  : delayed raw beat, running/final count, end and frame-error flags
module cnt1_stream
    import cnt1_pkg::*;
#(
    parameter int VECTOR_WIDTH  = 920,
    parameter int BUS_WIDTH     = 128,
    parameter int SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
    parameter int ADDER_STAGES  = 3,
    parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH + 1)
) (
    input  logic         clk,
    input  logic         rstn,
    cnt1_stream_if.slave bus
);
    localparam int LAST_BITS      = last_bits(VECTOR_WIDTH, BUS_WIDTH, SUB_VECTOR_NO);
    localparam int BEAT_CNT_WIDTH = beat_cnt_width(BUS_WIDTH);
    localparam int IDX_W          = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
    localparam int ST             = ADDER_STAGES;

    logic en;
    logic accept;

    // Whole pipe moves as one; an empty output slot never blocks.
    assign en           = bus.dn_Ready || !bus.dn_Valid;
    assign bus.up_Ready = en;
    assign accept       = bus.up_Valid && en;

    // ---------------- input beat index and mode latch ----------------
    logic [IDX_W-1:0] r_BeatIdx;
    logic             r_Mode;
    logic             in_last_idx;
    logic             in_first;
    logic             in_end;
    logic             in_err;
    logic             in_mode;

    assign in_last_idx = (r_BeatIdx == IDX_W'(SUB_VECTOR_NO - 1));
    assign in_first    = (r_BeatIdx == '0);
    assign in_end      = in_last_idx || bus.up_Last;
    assign in_err      = in_last_idx != bus.up_Last;
    // Beat 0 uses the live config; later beats use the value latched on beat 0.
    assign in_mode     = in_first ? bus.cfg_CountZeros : r_Mode;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_BeatIdx <= '0;
            r_Mode    <= 1'b0;
        end else if (accept) begin
            r_BeatIdx <= in_end ? '0 : r_BeatIdx + 1'b1;
            if (in_first) begin
                r_Mode <= bus.cfg_CountZeros;
            end
        end
    end

    // ---------------- mask / invert ----------------
    logic [BUS_WIDTH-1:0] valid_mask;
    logic [BUS_WIDTH-1:0] cnt_word;

    always_comb begin
        valid_mask = '1;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            valid_mask[i] = !in_last_idx || (i < LAST_BITS);
        end
    end

    // Inversion is confined to valid bits so pad bits are never counted as zeros.
    assign cnt_word = (bus.up_Vector & valid_mask) ^ ({BUS_WIDTH{in_mode}} & valid_mask);

    // ---------------- sideband and raw-data delay line ----------------
    sb_t                  r_sb   [ST+1];
    logic [BUS_WIDTH-1:0] r_data [ST+1];
    logic [BUS_WIDTH-1:0] r_word;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k <= ST; k++) begin
                r_sb[k] <= '0;
            end
        end else if (en) begin
            r_sb[0] <= '{valid:  accept,
                         first:  in_first,
                         is_end: in_end,
                         err:    in_err,
                         last:   bus.up_Last,
                         mode:   in_mode};
            for (int k = 1; k <= ST; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            r_data[0] <= bus.up_Vector;
            r_word    <= cnt_word;
            for (int k = 1; k <= ST; k++) begin
                r_data[k] <= r_data[k-1];
            end
        end
    end

    // ---------------- popcount tree ----------------
    logic [BEAT_CNT_WIDTH-1:0] beat_sum;

    popcnt_tree #(
        .WIDTH  (BUS_WIDTH),
        .STAGES (ADDER_STAGES)
    ) u_tree (
        .clk      (clk),
        .i_Vector (r_word),
        .i_En     (en),
        .o_Sum    (beat_sum)
    );

    // ---------------- accumulate / output register ----------------
    logic [CNT_WIDTH-1:0] r_Acc;
    logic [BUS_WIDTH-1:0] r_SubVector;
    logic                 r_Valid;
    logic                 r_Last;
    logic                 r_CntNew;
    logic                 r_FrameErr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_Acc       <= '0;
            r_SubVector <= '0;
            r_Valid     <= 1'b0;
            r_Last      <= 1'b0;
            r_CntNew    <= 1'b0;
            r_FrameErr  <= 1'b0;
        end else if (en) begin
            r_Valid    <= r_sb[ST].valid;
            r_Last     <= r_sb[ST].valid && r_sb[ST].last;
            r_CntNew   <= r_sb[ST].valid && r_sb[ST].is_end;
            r_FrameErr <= r_sb[ST].valid && r_sb[ST].is_end && r_sb[ST].err;
            if (r_sb[ST].valid) begin
                r_SubVector <= r_data[ST];
                r_Acc       <= (r_sb[ST].first ? '0 : r_Acc) + CNT_WIDTH'(beat_sum);
            end
        end
    end

    assign bus.dn_SubVector = r_SubVector;
    assign bus.dn_Valid     = r_Valid;
    assign bus.dn_Last      = r_Last;
    assign bus.dn_Cnt       = r_Acc;
    assign bus.dn_CntNew    = r_CntNew;
    assign bus.dn_FrameErr  = r_FrameErr;
endmodule

// File: tb/tb_cnt1_stream.sv
// tb/tb_cnt1_stream.sv - scoreboard bench for cnt1_stream
module tb_cnt1_stream;
    localparam int VW        = 920;
    localparam int BW        = 128;
    localparam int SVN       = 8;
    localparam int ST        = 3;
    localparam int CW        = 10;
    localparam int LAT       = ST + 2;
    localparam int LAST_BITS = VW - (SVN - 1) * BW;
    localparam logic [BW-1:0] LAST_MASK = (128'd1 << LAST_BITS) - 128'd1;
    localparam logic [BW-1:0] ONES      = '1;
    localparam logic [BW-1:0] ZERO      = '0;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    logic lat_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cnt1_stream_if #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) bus ();

    cnt1_stream #(
        .VECTOR_WIDTH  (VW),
        .BUS_WIDTH     (BW),
        .SUB_VECTOR_NO (SVN),
        .ADDER_STAGES  (ST),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
        logic          cntnew;
        logic          ferr;
        logic [CW-1:0] cnt;
        int            cyc;
        logic          lat;
    } exp_t;

    typedef struct {
        logic [CW-1:0] cnt;
        logic          err;
    } fin_t;

    exp_t sb_q [$];
    fin_t obs_q [$];

    task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state, advanced on every accepted beat.
    int            m_idx  = 0;
    logic          m_mode = 1'b0;
    int            m_acc  = 0;

    always @(negedge clk) begin : monitor
        exp_t          e;
        fin_t          f;
        logic          lidx, first, mode, endv, errv;
        logic [BW-1:0] mask;
        int            bc;
        if (!rstn) begin
            sb_q.delete();
            m_idx  = 0;
            m_mode = 1'b0;
            m_acc  = 0;
        end else begin
            if (!bus.dn_Valid) begin
                check("flag_qual", {bus.dn_CntNew, bus.dn_FrameErr}, 0);
            end
            if (bus.dn_Valid && bus.dn_Ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("data",   bus.dn_SubVector, e.data);
                    check("last",   bus.dn_Last,      e.last);
                    check("cntnew", bus.dn_CntNew,    e.cntnew);
                    check("ferr",   bus.dn_FrameErr,  e.ferr);
                    check("cnt",    bus.dn_Cnt,       e.cnt);
                    if (e.lat) check("latency", cyc - e.cyc, LAT);
                    if (bus.dn_CntNew) begin
                        f.cnt = bus.dn_Cnt;
                        f.err = bus.dn_FrameErr;
                        obs_q.push_back(f);
                    end
                end
            end
            if (bus.up_Valid && bus.up_Ready) begin
                lidx  = (m_idx == SVN - 1);
                first = (m_idx == 0);
                mode  = first ? bus.cfg_CountZeros : m_mode;
                if (first) m_mode = bus.cfg_CountZeros;
                mask  = lidx ? LAST_MASK : ONES;
                bc    = mode ? $countones(~bus.up_Vector & mask) : $countones(bus.up_Vector & mask);
                m_acc = (first ? 0 : m_acc) + bc;
                endv  = lidx || bus.up_Last;
                errv  = lidx != bus.up_Last;
                e.data   = bus.up_Vector;
                e.last   = bus.up_Last;
                e.cntnew = endv;
                e.ferr   = endv && errv;
                e.cnt    = CW'(m_acc);
                e.cyc    = cyc;
                e.lat    = lat_en;
                sb_q.push_back(e);
                m_idx = endv ? 0 : m_idx + 1;
            end
        end
    end

    task automatic drive(input logic [BW-1:0] d, input logic l, input logic m);
        int   n;
        logic acc;
        n = 0;
        bus.up_Vector      = d;
        bus.up_Last        = l;
        bus.cfg_CountZeros = m;
        bus.up_Valid       = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.up_Ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("accept_timeout", 0, 1);
        bus.up_Valid = 1'b0;
    endtask

    task automatic send_vec(input logic [BW-1:0] b0, input logic [BW-1:0] rest, input int nb,
                            input logic last_end, input logic mode, input int tog);
        for (int i = 0; i < nb; i++) begin
            drive((i == 0) ? b0 : rest, last_end && (i == nb - 1), (i == tog) ? ~mode : mode);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_final(input string tag, input int cnt, input logic err);
        fin_t f;
        if (obs_q.size() == 0) begin
            check({tag, "_missing"}, 0, 1);
        end else begin
            f = obs_q.pop_front();
            check(tag, f.cnt, cnt);
            check({tag, "_ferr"}, f.err, err);
        end
    endtask

    logic [BW-1:0] h_data;
    logic [CW-1:0] h_cnt;

    initial begin
        rstn               = 1'b0;
        bus.dn_Ready       = 1'b0;
        bus.up_Valid       = 1'b0;
        bus.up_Last        = 1'b0;
        bus.up_Vector      = '0;
        bus.cfg_CountZeros = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  bus.dn_Valid,     0);
        check("rst_last",   bus.dn_Last,      0);
        check("rst_cntnew", bus.dn_CntNew,    0);
        check("rst_ferr",   bus.dn_FrameErr,  0);
        check("rst_cnt",    bus.dn_Cnt,       0);
        check("rst_data",   bus.dn_SubVector, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", bus.up_Ready, 1);
        @(posedge clk);
        #1;
        bus.dn_Ready = 1'b1;

        // full all-ones vector, ones mode, with latency check
        lat_en = 1'b1;
        send_vec(ONES, ONES, 8, 1'b1, 1'b0, -1);
        drain();
        lat_en = 1'b0;
        expect_final("ones_vec", 920, 1'b0);

        // zeros mode and mid-vector config change
        send_vec(ZERO, ZERO, 8, 1'b1, 1'b1, -1);
        send_vec(ONES, ONES, 8, 1'b1, 1'b1, -1);
        send_vec(ONES, ONES, 8, 1'b1, 1'b0, 4);
        drain();
        expect_final("zeros_of_zero", 920, 1'b0);
        expect_final("zeros_of_ones", 0,   1'b0);
        expect_final("mode_toggle",   920, 1'b0);

        // downstream stall mid-vector
        fork
            send_vec(ONES, ONES, 8, 1'b1, 1'b0, -1);
            begin
                repeat (7) @(posedge clk);
                #1;
                bus.dn_Ready = 1'b0;
                @(negedge clk);
                check("stall_valid", bus.dn_Valid, 1);
                check("stall_rdy",   bus.up_Ready, 0);
                h_data = bus.dn_SubVector;
                h_cnt  = bus.dn_Cnt;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_rdy",   bus.up_Ready,     0);
                    check("stall_hold_v", bus.dn_Valid,    1);
                    check("stall_hold_d", bus.dn_SubVector, h_data);
                    check("stall_hold_c", bus.dn_Cnt,       h_cnt);
                end
                @(posedge clk);
                #1;
                bus.dn_Ready = 1'b1;
            end
        join
        drain();
        expect_final("stall_vec", 920, 1'b0);

        // frame errors: early up_Last, then missing up_Last
        send_vec(ONES, ONES, 4, 1'b1, 1'b0, -1);
        send_vec(ONES, ONES, 8, 1'b1, 1'b0, -1);
        send_vec(ONES, ONES, 8, 1'b0, 1'b0, -1);
        send_vec(ONES, ONES, 8, 1'b1, 1'b0, -1);
        drain();
        expect_final("short_vec",   512, 1'b1);
        expect_final("after_short", 920, 1'b0);
        expect_final("no_last",     920, 1'b1);
        expect_final("after_nolast", 920, 1'b0);

        // reset in the middle of a vector
        send_vec(ONES, ONES, 4, 1'b0, 1'b0, -1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_valid", bus.dn_Valid, 0);
        check("midrst_rdy",   bus.up_Ready, 1);
        @(posedge clk);
        #1;
        send_vec(ONES, ONES, 8, 1'b1, 1'b0, -1);
        drain();
        expect_final("after_rst", 920, 1'b0);
        check("no_stale_out", obs_q.size(), 0);

        // alternating 1 / 919 back-to-back
        for (int r = 0; r < 2; r++) begin
            send_vec(128'd1,  ZERO, 8, 1'b1, 1'b0, -1);
            send_vec(~128'd1, ONES, 8, 1'b1, 1'b0, -1);
        end
        drain();
        expect_final("alt_1a",   1,   1'b0);
        expect_final("alt_919a", 919, 1'b0);
        expect_final("alt_1b",   1,   1'b0);
        expect_final("alt_919b", 919, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cnt1_stream.md
# cnt1_stream

Streaming per-vector popcount engine. The next generation of the sub-vector bit counter: it takes a VECTOR_WIDTH-bit vector split across SUB_VECTOR_NO bus beats and forwards each beat unchanged, together with a running and final ones/zeros count per vector. Over the previous block it adds:
- masking of pad bits on the final beat;
- a per-vector count-zeros mode;
- frame-error detection against up_Last;
- a proper valid/ready stall that does not block while the output is empty.

It sits between the vector reader and the Tanimoto/similarity stage.

## Interface
Parameters:
- VECTOR_WIDTH, 920, bits per full vector.
- BUS_WIDTH, 128, bits per beat.
- SUB_VECTOR_NO, ceil(VECTOR_WIDTH/BUS_WIDTH), beats per vector.
- ADDER_STAGES, 3, register levels in the popcount tree (≥1).
- CNT_WIDTH, $clog2(VECTOR_WIDTH+1), width of the vector count.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; rstn synchronous, active-low; clock clk.
- up_Vector  in  BUS_WIDTH  input beat.
- up_Valid  in  1  beat valid.
- up_Last  in  1  last beat of the vector, as marked by the source.
- cfg_CountZeros  in  1  count zeros instead of ones; sampled on beat 0 of each vector.
- up_Ready  out  1  beat accepted when up_Valid && up_Ready.
- dn_SubVector  out  BUS_WIDTH  delayed raw (unmasked) beat.
- dn_Valid  out  1  output beat valid.
- dn_Last  out  1  delayed up_Last.
- dn_Cnt  out  CNT_WIDTH  running count of the vector, including the current output beat.
- dn_CntNew  out  1  current output beat ends a vector; dn_Cnt is the final count.
- dn_FrameErr  out  1  qualifies dn_CntNew; vector end and up_Last disagreed.
- dn_Ready  in  1  downstream ready.

## Operation
- **Pipeline enable:** en = dn_Ready || !dn_Valid. up_Ready = en.
  - All stages advance together when en is high.
  - Internal bubbles are not collapsed.
- **Input beat index:** r_BeatIdx advances on each accepted beat.
  - A beat is the vector end when r_BeatIdx == SUB_VECTOR_NO-1 or up_Last is high.
  - At the vector end r_BeatIdx returns to 0.
- **Frame error:** set for the end beat when (r_BeatIdx == SUB_VECTOR_NO-1) != up_Last. The count is still emitted, and the next beat is beat 0.
- **Pad mask:** on the beat with r_BeatIdx == SUB_VECTOR_NO-1, bits ≥ LAST_BITS are forced to 0 before counting.
  - LAST_BITS = VECTOR_WIDTH-(SUB_VECTOR_NO-1)*BUS_WIDTH.
  - Other beats are unmasked.
- **Counting:** the counted word is masked ^ ({BUS_WIDTH{mode}} & valid-bit mask).
  - In zeros mode, pad bits are never counted.
  - mode is latched on beat 0 and held for the whole vector; changes mid-vector are ignored.
- **Sideband through the pipe:** first-beat, end, err and last flags travel alongside the beat. The popcount tree output is BEAT_CNT_WIDTH = $clog2(BUS_WIDTH+1).
- **Accumulator** (output stage): r_Acc <= (first ? 0 : r_Acc) + zero-extended beat sum. dn_Cnt = r_Acc.
- **Widths:** the sum never exceeds VECTOR_WIDTH, so there is no saturation.
- **Vector lengths:** a vector longer than SUB_VECTOR_NO beats cannot occur, because index wrap ends it. Short vectors end early on up_Last.

## Timing
- **Latency:** LAT = ADDER_STAGES+2 cycles from an accepted beat to dn_Valid, with no stalls.
  - Stage 0: mask/invert register.
  - Stages 1..ADDER_STAGES: tree.
  - Final stage: accumulate and output register.
- **Throughput:** 1 beat/cycle while dn_Ready is high.
- **Stall:** while dn_Valid && !dn_Ready, all dn_* outputs are held stable and up_Ready = 0.
- **Reset outputs:** dn_Valid, dn_Last, dn_CntNew, dn_FrameErr, dn_Cnt and dn_SubVector are all 0.
- **Reset state:** r_BeatIdx = 0, all pipe valid flags 0, and the latched mode is 0.
- **up_Ready after reset:** 1 on the first cycle after rstn rises.
- **Reset mid-vector:** the partial vector and all in-flight beats are discarded. The next accepted beat is beat 0.
- **Back-to-back vectors:** a new vector's beat 0 may directly follow the previous end beat. The accumulator restarts on the first flag, with no dead cycle.
- **Output flags:** dn_CntNew and dn_FrameErr are only ever high together with dn_Valid.

## Structure
- **Shared package cnt1_pkg:**
  - LAST_BITS, LAT and BEAT_CNT_WIDTH derivations;
  - the pipe sideband struct {valid, first, end, err, last, mode}.
- **Sub-module popcnt_tree:** pipelined adder tree with parameters WIDTH and STAGES, inputs i_Vector and i_En, output o_Sum.
  - Balanced, and reused by later blocks.
  - It replaces the fixed-granule counter.
- **Top level:** index counter, mask stage, sideband shift register and accumulator.

## Test plan
VECTOR_WIDTH=920, BUS_WIDTH=128, SUB_VECTOR_NO=8, ADDER_STAGES=3 (LAT=5, LAST_BITS=24).
- 8 all-ones beats back-to-back, ones mode -> dn_CntNew on the 8th output beat, 5 cycles after its input; dn_Cnt=920 (pad masked); dn_FrameErr=0.
- All-zero vector in zeros mode -> 920. All-ones vector in zeros mode -> 0. cfg_CountZeros toggled on beat 4 -> no effect.
- dn_Ready held low 5 cycles mid-vector -> up_Ready low the same cycles, outputs held, no beat lost or duplicated, final count unchanged.
- up_Last on beat 3, all ones -> dn_CntNew with dn_Cnt=512 and dn_FrameErr=1; the next vector counts from 0. An 8th beat without up_Last -> dn_FrameErr=1.
- rstn low for 1 cycle after 4 beats -> dn_Valid=0 the next cycle; the following full vector reports the correct count.
- Alternating vectors with counts 1 and 919, back-to-back -> dn_Cnt 1, 919, 1, 919 at each dn_CntNew.
